// File: rtl/usb_kbd_event_fifo.sv
// Keyboard report differ: turns successive HID keyboard reports into per-key press/release
// events and queues them in a first-word-fall-through FIFO behind a valid/ready stream.
module usb_kbd_event_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic               usbclk,
    input  logic               usbrst_n,
    input  logic [1:0]         typ,
    input  logic               report,
    input  logic [7:0]         key_modifiers,
    input  logic [7:0]         key1,
    input  logic [7:0]         key2,
    input  logic [7:0]         key3,
    input  logic [7:0]         key4,
    output logic               evt_valid,
    output logic [8:0]         evt_data,
    input  logic               evt_ready,
    output logic [FIFO_AW:0]   evt_count,
    output logic               overflow,
    input  logic               overflow_clr,
    output logic               busy
);
    localparam int DEPTH = 2 ** FIFO_AW;

    // keys[0] holds key1; a whole report is one 40-bit word.
    typedef struct packed {
        logic [7:0]      mods;
        logic [3:0][7:0] keys;
    } rpt_t;

    typedef enum logic [2:0] {S_IDLE, S_MOD, S_REL, S_PRS, S_COMMIT} state_t;

    state_t       state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    rpt_t         incoming, pend, cur, prev;
    logic         pend_v;
    logic [1:0]   typ_q;
    logic         rollover, capture, disconnect, take;
    logic         emit;
    logic [8:0]   emit_data;
    logic [7:0]   rel_key, prs_key;
    logic         rel_hit, prs_hit;

    assign incoming   = {key_modifiers, key4, key3, key2, key1};
    assign capture    = report && (typ == 2'd1) && !rollover;
    assign disconnect = (typ_q == 2'd1) && (typ != 2'd1) && (prev != '0);
    assign take       = (state_q == S_IDLE) && pend_v;
    assign busy       = (state_q != S_IDLE);

    always_comb begin
        rollover = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (incoming.keys[j] != 8'h00 && incoming.keys[j] <= 8'h03) rollover = 1'b1;
        end
    end

    // Pending report slot; disconnect synthesises an all-released report.
    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            typ_q  <= 2'd0;
            pend   <= '0;
            pend_v <= 1'b0;
        end else begin
            typ_q <= typ;
            if (disconnect) begin
                pend   <= '0;
                pend_v <= 1'b1;
            end else if (capture) begin
                pend   <= incoming;
                pend_v <= 1'b1;
            end else if (take) begin
                pend_v <= 1'b0;
            end
        end
    end

    always_comb begin
        rel_key = prev.keys[idx_q[1:0]];
        prs_key = cur.keys[idx_q[1:0]];
        rel_hit = 1'b0;
        prs_hit = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (cur.keys[j] == rel_key)  rel_hit = 1'b1;
            if (prev.keys[j] == prs_key) prs_hit = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        emit      = 1'b0;
        emit_data = 9'h000;
        case (state_q)
            S_IDLE: begin
                if (pend_v) begin
                    state_d = S_MOD;
                    idx_d   = 3'd0;
                end
            end
            S_MOD: begin
                if (cur.mods[idx_q] != prev.mods[idx_q]) begin
                    emit      = 1'b1;
                    emit_data = {cur.mods[idx_q], 5'b11100, idx_q};
                end
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = S_REL;
            end
            S_REL: begin
                if (rel_key != 8'h00 && !rel_hit) begin
                    emit      = 1'b1;
                    emit_data = {1'b0, rel_key};
                end
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd3) begin
                    state_d = S_PRS;
                    idx_d   = 3'd0;
                end
            end
            S_PRS: begin
                if (prs_key != 8'h00 && !prs_hit) begin
                    emit      = 1'b1;
                    emit_data = {1'b1, prs_key};
                end
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd3) begin
                    state_d = S_COMMIT;
                    idx_d   = 3'd0;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cur     <= '0;
            prev    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (take) cur <= pend;
            if (state_q == S_COMMIT) prev <= cur;
        end
    end

    // Valid/ready: a beat transfers on any edge where evt_valid and evt_ready are both high;
    // evt_data is stable while evt_valid is high and the head has not been popped.
    logic [8:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic               pop, push_ok, drop;

    assign evt_valid = (evt_count != '0);
    assign evt_data  = mem[rd_ptr];
    assign pop       = evt_valid && evt_ready;
    assign push_ok   = emit && ((evt_count < (FIFO_AW+1)'(DEPTH)) || pop);
    assign drop      = emit && !push_ok;

    always_ff @(posedge usbclk) begin
        if (push_ok) mem[wr_ptr] <= emit_data;
    end

    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      evt_count <= evt_count + 1'b1;
            else if (pop && !push_ok) evt_count <= evt_count - 1'b1;
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_usb_kbd_event_fifo.sv
// Directed bench for usb_kbd_event_fifo: table of reports with expected event lists,
// plus hand sequences for latency, overflow, disconnect, back-to-back reports and reset.
module tb_usb_kbd_event_fifo;
    logic       usbclk = 1'b0;
    logic       usbrst_n;
    logic [1:0] typ;
    logic       report;
    logic [7:0] key_modifiers, key1, key2, key3, key4;
    logic       evt_valid;
    logic [8:0] evt_data;
    logic       evt_ready;
    logic [4:0] evt_count;
    logic       overflow;
    logic       overflow_clr;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    usb_kbd_event_fifo #(.FIFO_AW(4)) dut (
        .usbclk(usbclk), .usbrst_n(usbrst_n), .typ(typ), .report(report),
        .key_modifiers(key_modifiers), .key1(key1), .key2(key2), .key3(key3), .key4(key4),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
        .evt_count(evt_count), .overflow(overflow), .overflow_clr(overflow_clr), .busy(busy)
    );

    always #5 usbclk = ~usbclk;

    // Record each beat just before the edge that pops it.
    always @(negedge usbclk) begin
        if (usbrst_n && evt_valid && evt_ready) got_q.push_back(evt_data);
    end

    typedef struct {
        string           name;
        logic            pulse;
        logic [1:0]      t;
        logic [7:0]      m, k1, k2, k3, k4;
        int              n;
        logic [0:4][8:0] e;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge usbclk);
        #1;
    endtask

    task automatic check_events(input string name);
        logic [31:0] act;
        chk({name, "_num_events"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            act = (i < got_q.size()) ? {23'd0, got_q[i]} : 32'hFFFF_FFFF;
            chk($sformatf("%s_event%0d", name, i), act, {23'd0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Leaves the bench 1 time unit after the edge that sampled the report pulse.
    task automatic drive_report(input logic pulse, input logic [1:0] t, input logic [7:0] m,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d);
        @(posedge usbclk);
        #1;
        typ = t; key_modifiers = m; key1 = a; key2 = b; key3 = c; key4 = d;
        report = pulse;
        @(posedge usbclk);
        #1;
        report = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"press04",      1, 2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 1, {9'h104, 9'h0, 9'h0, 9'h0, 9'h0}};
        vecs[1]  = '{"release04",    1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, {9'h004, 9'h0, 9'h0, 9'h0, 9'h0}};
        vecs[2]  = '{"mods12",       1, 2'd1, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 2, {9'h1E1, 9'h1E4, 9'h0, 9'h0, 9'h0}};
        vecs[3]  = '{"mods02",       1, 2'd1, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 1, {9'h0E4, 9'h0, 9'h0, 9'h0, 9'h0}};
        vecs[4]  = '{"mods00",       1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, {9'h0E1, 9'h0, 9'h0, 9'h0, 9'h0}};
        vecs[5]  = '{"hold04",       1, 2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 1, {9'h104, 9'h0, 9'h0, 9'h0, 9'h0}};
        vecs[6]  = '{"rollover01",   1, 2'd1, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 0, {9'h0, 9'h0, 9'h0, 9'h0, 9'h0}};
        vecs[7]  = '{"rollover_s3",  1, 2'd1, 8'h00, 8'h09, 8'h00, 8'h02, 8'h00, 0, {9'h0, 9'h0, 9'h0, 9'h0, 9'h0}};
        vecs[8]  = '{"after_roll",   1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, {9'h004, 9'h0, 9'h0, 9'h0, 9'h0}};
        vecs[9]  = '{"press0405",    1, 2'd1, 8'h00, 8'h04, 8'h05, 8'h00, 8'h00, 2, {9'h104, 9'h105, 9'h0, 9'h0, 9'h0}};
        vecs[10] = '{"reorder",      1, 2'd1, 8'h00, 8'h05, 8'h04, 8'h00, 8'h00, 0, {9'h0, 9'h0, 9'h0, 9'h0, 9'h0}};
        vecs[11] = '{"dup06",        1, 2'd1, 8'h00, 8'h04, 8'h05, 8'h06, 8'h06, 2, {9'h106, 9'h106, 9'h0, 9'h0, 9'h0}};
        vecs[12] = '{"swap_to07",    1, 2'd1, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 5, {9'h004, 9'h005, 9'h006, 9'h006, 9'h107}};
        vecs[13] = '{"mods81",       1, 2'd1, 8'h81, 8'h07, 8'h00, 8'h00, 8'h00, 2, {9'h1E0, 9'h1E7, 9'h0, 9'h0, 9'h0}};
        vecs[14] = '{"disconnect",   0, 2'd0, 8'h81, 8'h07, 8'h00, 8'h00, 8'h00, 3, {9'h0E0, 9'h0E7, 9'h007, 9'h0, 9'h0}};
        vecs[15] = '{"typ2_ignored", 1, 2'd2, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 0, {9'h0, 9'h0, 9'h0, 9'h0, 9'h0}};
        vecs[16] = '{"press0a",      1, 2'd1, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 1, {9'h10A, 9'h0, 9'h0, 9'h0, 9'h0}};
        vecs[17] = '{"release0a",    1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, {9'h00A, 9'h0, 9'h0, 9'h0, 9'h0}};

        // Clock/reset
        usbrst_n = 1'b0; typ = 2'd1; report = 1'b0; key_modifiers = 8'h00;
        key1 = 8'h00; key2 = 8'h00; key3 = 8'h00; key4 = 8'h00;
        evt_ready = 1'b1; overflow_clr = 1'b0;
        cycles(3);
        usbrst_n = 1'b1;
        cycles(1);
        chk("reset_evt_valid", evt_valid, 0);
        chk("reset_evt_count", evt_count, 0);
        chk("reset_overflow",  overflow,  0);
        chk("reset_busy",      busy,      0);

        // Minimum latency: event visible on the third edge after the report pulse.
        drive_report(1'b1, 2'd1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("latency_edge1", evt_valid, 0);
        cycles(1);
        chk("latency_edge2", evt_valid, 0);
        cycles(1);
        chk("latency_edge3", evt_valid, 1);
        exp_q.push_back(9'h1E0);
        cycles(22);
        check_events("latency");
        drive_report(1'b1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        exp_q.push_back(9'h0E0);
        cycles(24);
        check_events("latency_rel");

        // Table-driven reports
        for (int v = 0; v < 18; v++) begin
            drive_report(vecs[v].pulse, vecs[v].t, vecs[v].m,
                         vecs[v].k1, vecs[v].k2, vecs[v].k3, vecs[v].k4);
            for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(vecs[v].e[i]);
            cycles(24);
            check_events(vecs[v].name);
        end
        chk("table_count_empty", evt_count, 0);
        chk("table_overflow",    overflow,  0);

        // Disconnect releases held keys; busy must rise and then fall back.
        drive_report(1'b1, 2'd1, 8'h00, 8'h04, 8'h05, 8'h00, 8'h00);
        exp_q.push_back(9'h104); exp_q.push_back(9'h105);
        cycles(24);
        check_events("disc_press");
        @(posedge usbclk); #1;
        typ = 2'd0;
        begin
            int k;
            k = 0;
            while (!busy && k < 6) begin cycles(1); k++; end
            chk("disc_busy_rise", busy, 1);
            k = 0;
            while (busy && k < 30) begin cycles(1); k++; end
            chk("disc_busy_fall", busy, 0);
        end
        exp_q.push_back(9'h004); exp_q.push_back(9'h005);
        cycles(4);
        check_events("disconnect_keys");
        typ = 2'd1;
        cycles(2);

        // Overflow: 5 reports x 4 events into a 16-deep FIFO with no consumer.
        evt_ready = 1'b0;
        for (int r = 0; r < 5; r++) begin
            if (r % 2 == 0) drive_report(1'b1, 2'd1, 8'h00, 8'h04, 8'h05, 8'h06, 8'h07);
            else            drive_report(1'b1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
            cycles(22);
        end
        chk("ovf_count_full", evt_count, 16);
        chk("ovf_sticky",     overflow,  1);
        chk("ovf_valid",      evt_valid, 1);
        overflow_clr = 1'b1;
        cycles(1);
        overflow_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);
        // Clear held through the release drops: each drop must win over the clear.
        overflow_clr = 1'b1;
        drive_report(1'b1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        cycles(13);
        chk("ovf_drop_beats_clr", overflow, 1);
        overflow_clr = 1'b0;
        cycles(10);
        chk("ovf_still_sticky", overflow, 1);
        chk("ovf_count_held",   evt_count, 16);
        overflow_clr = 1'b1;
        cycles(1);
        overflow_clr = 1'b0;
        chk("ovf_cleared2", overflow, 0);
        for (int r = 0; r < 4; r++) begin
            for (int k = 4; k < 8; k++) exp_q.push_back({(r % 2 == 0) ? 1'b1 : 1'b0, 8'(k)});
        end
        evt_ready = 1'b1;
        cycles(20);
        check_events("ovf_drain");
        chk("ovf_count_drained", evt_count, 0);

        // Second report lands mid-scan; it is diffed against the first once committed.
        drive_report(1'b1, 2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
        cycles(4);
        drive_report(1'b1, 2'd1, 8'h00, 8'h04, 8'h05, 8'h00, 8'h00);
        exp_q.push_back(9'h104); exp_q.push_back(9'h105);
        cycles(40);
        check_events("midscan");
        drive_report(1'b1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        exp_q.push_back(9'h004); exp_q.push_back(9'h005);
        cycles(24);
        check_events("midscan_rel");

        // Reset mid-scan: everything clears at once and nothing is committed.
        evt_ready = 1'b0;
        drive_report(1'b1, 2'd1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
        cycles(6);
        chk("rst_pre_count", evt_count, 5);
        usbrst_n = 1'b0;
        #1;
        chk("rst_mid_count", evt_count, 0);
        chk("rst_mid_valid", evt_valid, 0);
        chk("rst_mid_busy",  busy,      0);
        cycles(2);
        usbrst_n = 1'b1;
        evt_ready = 1'b1;
        cycles(2);
        drive_report(1'b1, 2'd1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 5'b11100, 3'(i)});
        cycles(24);
        check_events("rst_no_commit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
